// File: rtl/text_console_pkg.sv
// Shared constants, control codes, cell layout and FSM states for the text console writer.
// The TAB state exists only when TEXT_CONSOLE_TAB_EN is defined.
package text_console_pkg;

  localparam int COLS     = 80;
  localparam int ROWS     = 30;
  localparam int FB_DEPTH = 2400;
  localparam int FB_AW    = 12;

  localparam logic [7:0] CH_BS    = 8'h08;
  localparam logic [7:0] CH_HT    = 8'h09;
  localparam logic [7:0] CH_LF    = 8'h0A;
  localparam logic [7:0] CH_FF    = 8'h0C;
  localparam logic [7:0] CH_CR    = 8'h0D;
  localparam logic [7:0] CH_SPACE = 8'h20;

  typedef struct packed {
    logic [7:0] attr;
    logic [7:0] chr;
  } cell_t;

`ifdef TEXT_CONSOLE_TAB_EN
  typedef enum logic [2:0] {IDLE, EXEC, CLR_LINE, CLR_SCREEN, TAB} state_t;
`else
  typedef enum logic [2:0] {IDLE, EXEC, CLR_LINE, CLR_SCREEN} state_t;
`endif

  // row*80 as (row<<6)+(row<<4), kept in frame-buffer address width
  function automatic logic [FB_AW-1:0] row_base(input logic [4:0] row);
    logic [FB_AW-1:0] r;
    r = {{(FB_AW-5){1'b0}}, row};
    return (r << 6) + (r << 4);
  endfunction

endpackage

// File: rtl/console_clear_seq.sv
// Emits len consecutive write strobes from base upward, with a done pulse on the last one.
// The address holds at the final cell instead of wrapping.
module console_clear_seq
  import text_console_pkg::*;
(
  input  logic             CLK,
  input  logic             RST,
  input  logic             start,
  input  logic [FB_AW-1:0] base,
  input  logic [FB_AW-1:0] len,
  output logic             we,
  output logic [FB_AW-1:0] addr,
  output logic             done
);

  logic [FB_AW-1:0] remain_q;

  always_ff @(posedge CLK) begin
    if (RST) begin
      we       <= 1'b0;
      addr     <= '0;
      remain_q <= '0;
    end else if (start) begin
      we       <= 1'b1;
      addr     <= base;
      remain_q <= len - 12'd1;
    end else if (we) begin
      if (remain_q == '0) begin
        we <= 1'b0;
      end else begin
        addr     <= addr + 12'd1;
        remain_q <= remain_q - 12'd1;
      end
    end
  end

  assign done = we && (remain_q == '0);

endmodule

// File: rtl/text_console_writer.sv
// Byte-stream text console: decodes characters/control codes, owns the cursor and writes
// {attr, char} cells into the 80x30 frame buffer. Optional HT support: TEXT_CONSOLE_TAB_EN.
module text_console_writer #(
  parameter int         COLS         = 80,
  parameter int         ROWS         = 30,
  parameter logic [7:0] CLEAR_ATTR   = 8'h07,
  parameter bit         CLEAR_ON_RST = 1'b1
) (
  input  logic        CLK,
  input  logic        RST,
  input  logic        in_valid,
  output logic        in_ready,
  input  logic [7:0]  in_char,
  input  logic [7:0]  in_attr,
  output logic        fb_we,
  output logic [11:0] fb_addr,
  output logic [15:0] fb_wdata,
  output logic [6:0]  cursor_col,
  output logic [4:0]  cursor_row,
  output logic        busy,
  output logic [2:0]  dbg_state
);
  import text_console_pkg::*;

  localparam cell_t CLEAR_CELL = '{attr: CLEAR_ATTR, chr: CH_SPACE};

  // Handshake: a byte transfers on a rising edge where in_valid && in_ready; in_ready is
  // high only while IDLE, and the source must hold in_valid/in_char/in_attr until then.
  state_t     state_q, state_d, after_q, after_d;
  logic [6:0] col_q, col_d, adv_col;
  logic [4:0] row_q, row_d, adv_row, nl_row;
  logic       adv_wrap, printable;
  logic       wr_q, wr_d, ready_q, go_q, go_d;
  logic [11:0] wr_addr_q, wr_addr_d, cur_addr, clr_base_q, clr_len_q;
  cell_t      wr_data_q, wr_data_d;
  logic       seq_we, seq_done;
  logic [11:0] seq_addr;

  assign printable = (in_char >= 8'h20) && (in_char <= 8'h7E);
  assign cur_addr  = row_base(row_q) + {5'd0, col_q};
  assign nl_row    = (row_q == 5'(ROWS - 1)) ? 5'd0 : row_q + 5'd1;
  assign adv_wrap  = (col_q == 7'(COLS - 1));
  assign adv_col   = adv_wrap ? 7'd0 : col_q + 7'd1;
  assign adv_row   = adv_wrap ? nl_row : row_q;
  assign go_d      = ((state_d == CLR_LINE) || (state_d == CLR_SCREEN)) && (state_d != state_q);

  // Decode happens on the accepting edge so the cell write is visible during EXEC.
  always_comb begin
    state_d   = state_q;
    after_d   = after_q;
    col_d     = col_q;
    row_d     = row_q;
    wr_d      = 1'b0;
    wr_addr_d = wr_addr_q;
    wr_data_d = wr_data_q;
    case (state_q)
      IDLE: if (in_valid && ready_q) begin
        state_d = EXEC;
        after_d = IDLE;
        if (printable) begin
          wr_d      = 1'b1;
          wr_addr_d = cur_addr;
          wr_data_d = '{attr: in_attr, chr: in_char};
          col_d     = adv_col;
          row_d     = adv_row;
          if (adv_wrap) after_d = CLR_LINE;
        end else begin
          case (in_char)
            CH_CR: col_d = '0;
            CH_LF: begin
              col_d   = '0;
              row_d   = nl_row;
              after_d = CLR_LINE;
            end
            CH_BS: if (col_q != 7'd0) begin
              col_d     = col_q - 7'd1;
              wr_d      = 1'b1;
              wr_addr_d = cur_addr - 12'd1;
              wr_data_d = CLEAR_CELL;
            end
            CH_FF: begin
              col_d   = '0;
              row_d   = '0;
              after_d = CLR_SCREEN;
            end
`ifdef TEXT_CONSOLE_TAB_EN
            CH_HT: begin
              wr_d      = 1'b1;
              wr_addr_d = cur_addr;
              wr_data_d = CLEAR_CELL;
              col_d     = adv_col;
              row_d     = adv_row;
              after_d   = adv_wrap ? CLR_LINE : ((adv_col[2:0] == 3'd0) ? IDLE : TAB);
            end
`endif
            default: ;
          endcase
        end
      end
      EXEC:     state_d = after_q;
      CLR_LINE: if (seq_done) state_d = IDLE;
      CLR_SCREEN: if (seq_done) begin
        state_d = IDLE;
        col_d   = '0;
        row_d   = '0;
      end
`ifdef TEXT_CONSOLE_TAB_EN
      // The final tab write lands in EXEC, which then hands over to IDLE or CLR_LINE.
      TAB: begin
        wr_d      = 1'b1;
        wr_addr_d = cur_addr;
        wr_data_d = CLEAR_CELL;
        col_d     = adv_col;
        row_d     = adv_row;
        if (adv_wrap || (adv_col[2:0] == 3'd0)) begin
          state_d = EXEC;
          after_d = adv_wrap ? CLR_LINE : IDLE;
        end
      end
`endif
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge CLK) begin
    if (RST) begin
      state_q    <= CLEAR_ON_RST ? CLR_SCREEN : IDLE;
      after_q    <= IDLE;
      col_q      <= '0;
      row_q      <= '0;
      wr_q       <= 1'b0;
      wr_addr_q  <= '0;
      wr_data_q  <= '0;
      ready_q    <= 1'b0;
      go_q       <= CLEAR_ON_RST;
      clr_base_q <= '0;
      clr_len_q  <= 12'(FB_DEPTH);
    end else begin
      state_q   <= state_d;
      after_q   <= after_d;
      col_q     <= col_d;
      row_q     <= row_d;
      wr_q      <= wr_d;
      wr_addr_q <= wr_addr_d;
      wr_data_q <= wr_data_d;
      ready_q   <= (state_d == IDLE);
      go_q      <= go_d;
      if (go_d) begin
        clr_base_q <= (state_d == CLR_SCREEN) ? 12'd0 : row_base(row_d);
        clr_len_q  <= (state_d == CLR_SCREEN) ? 12'(FB_DEPTH) : 12'(COLS);
      end
    end
  end

  console_clear_seq u_clear (
    .CLK   (CLK),
    .RST   (RST),
    .start (go_q),
    .base  (clr_base_q),
    .len   (clr_len_q),
    .we    (seq_we),
    .addr  (seq_addr),
    .done  (seq_done)
  );

  assign fb_we      = wr_q | seq_we;
  assign fb_addr    = seq_we ? seq_addr : wr_addr_q;
  assign fb_wdata   = seq_we ? CLEAR_CELL : wr_data_q;
  assign in_ready   = ready_q;
  assign cursor_col = col_q;
  assign cursor_row = row_q;
  assign busy       = (state_q == CLR_LINE) || (state_q == CLR_SCREEN);
  assign dbg_state  = state_q;

endmodule

// File: tb/tb_text_console_writer.sv
// Directed + random bench for text_console_writer: a screen/cursor reference model predicts
// every frame-buffer write, which is compared in order against the writes seen on the port.
module tb_text_console_writer;

  localparam int W = 30; // {in_ready, busy, addr[11:0], data[15:0]}

  logic        CLK = 1'b0;
  logic        RST = 1'b1;
  logic        in_valid = 1'b0;
  logic [7:0]  in_char = 8'h00;
  logic [7:0]  in_attr = 8'h00;
  logic        in_ready, fb_we, busy;
  logic [11:0] fb_addr;
  logic [15:0] fb_wdata;
  logic [6:0]  cursor_col;
  logic [4:0]  cursor_row;
  logic [2:0]  dbg_state;

  int n_cmp = 0;
  int n_err = 0;
  int cyc = 0;
  int acc_cyc = 0;
  int m_col = 0;
  int m_row = 0;
  logic [11:0] lat_addr;
  logic [15:0] lat_data;
  logic [W-1:0] exp_q[$];
  logic [W-1:0] obs_q[$];

  text_console_writer dut (
    .CLK(CLK), .RST(RST), .in_valid(in_valid), .in_ready(in_ready),
    .in_char(in_char), .in_attr(in_attr), .fb_we(fb_we), .fb_addr(fb_addr),
    .fb_wdata(fb_wdata), .cursor_col(cursor_col), .cursor_row(cursor_row),
    .busy(busy), .dbg_state(dbg_state)
  );

  // clock / cycle count / write monitor
  always #5 CLK = ~CLK;
  always @(posedge CLK) cyc <= cyc + 1;
  always @(negedge CLK) if (fb_we === 1'b1) obs_q.push_back({in_ready, busy, fb_addr, fb_wdata});

  initial begin
    #900000;
    $display("FAIL watchdog: observed time %0t expected completion", $time);
    $fatal(1, "watchdog expired");
  end

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_cmp++;
    assert (obs === exp) else begin
      n_err++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  // ---------------- reference model ----------------
  function automatic logic [W-1:0] ent(input bit bsy, input int addr, input logic [15:0] d);
    return {1'b0, bsy, 12'(addr), d};
  endfunction

  task automatic push_line(input int row);
    for (int c = 0; c < 80; c++) exp_q.push_back(ent(1'b1, row * 80 + c, 16'h0720));
  endtask

  task automatic push_screen();
    for (int a = 0; a < 2400; a++) exp_q.push_back(ent(1'b1, a, 16'h0720));
  endtask

  task automatic model_byte(input logic [7:0] ch, input logic [7:0] at,
                            output bit wr, output logic [W-1:0] first);
    wr = 1'b0;
    first = '0;
    if (ch >= 8'h20 && ch <= 8'h7E) begin
      wr = 1'b1;
      first = ent(1'b0, m_row * 80 + m_col, {at, ch});
      exp_q.push_back(first);
      m_col++;
      if (m_col == 80) begin
        m_col = 0;
        m_row = (m_row + 1) % 30;
        push_line(m_row);
      end
    end else if (ch == 8'h0D) begin
      m_col = 0;
    end else if (ch == 8'h0A) begin
      m_col = 0;
      m_row = (m_row + 1) % 30;
      push_line(m_row);
    end else if (ch == 8'h08) begin
      if (m_col > 0) begin
        m_col--;
        wr = 1'b1;
        first = ent(1'b0, m_row * 80 + m_col, 16'h0720);
        exp_q.push_back(first);
      end
    end else if (ch == 8'h0C) begin
      m_col = 0;
      m_row = 0;
      push_screen();
    end
`ifdef TEXT_CONSOLE_TAB_EN
    else if (ch == 8'h09) begin
      wr = 1'b1;
      first = ent(1'b0, m_row * 80 + m_col, 16'h0720);
      do begin
        exp_q.push_back(ent(1'b0, m_row * 80 + m_col, 16'h0720));
        m_col++;
        if (m_col == 80) begin
          m_col = 0;
          m_row = (m_row + 1) % 30;
          push_line(m_row);
          break;
        end
      end while (m_col % 8 != 0);
    end
`endif
  endtask

  // ---------------- driver tasks (entered and left on a negedge) ----------------
  task automatic send(input logic [7:0] ch, input logic [7:0] at);
    int g;
    bit wr;
    logic [W-1:0] first;
    g = 0;
    while (in_ready !== 1'b1 && g < 6000) begin @(negedge CLK); g++; end
    if (in_ready !== 1'b1) begin
      chk("ready_timeout", 32'd0, 32'd1);
      return;
    end
    in_valid = 1'b1;
    in_char  = ch;
    in_attr  = at;
    model_byte(ch, at, wr, first);
    @(negedge CLK);
    in_valid = 1'b0;
    acc_cyc  = cyc;
    lat_addr = fb_addr;
    lat_data = fb_wdata;
    chk("lat_we", {31'd0, fb_we}, {31'd0, wr});
    if (wr) chk("lat_cell", {4'd0, fb_addr, fb_wdata}, {4'd0, first[27:0]});
  endtask

  task automatic drain(input string tag);
    int g;
    bit bad;
    logic [W-1:0] o, e;
    g = 0;
    bad = 1'b0;
    while (in_ready !== 1'b1 && g < 6000) begin @(negedge CLK); g++; end
    if (in_ready !== 1'b1) chk({tag, "_timeout"}, 32'd0, 32'd1);
    chk({tag, "_nwr"}, obs_q.size(), exp_q.size());
    while (exp_q.size() > 0 && obs_q.size() > 0 && !bad) begin
      e = exp_q.pop_front();
      o = obs_q.pop_front();
      chk({tag, "_wr"}, {2'd0, o}, {2'd0, e});
      if (o !== e) bad = 1'b1;
    end
    exp_q.delete();
    obs_q.delete();
    chk({tag, "_col"}, cursor_col, m_col);
    chk({tag, "_row"}, cursor_row, m_row);
    chk({tag, "_busy"}, busy, 32'd0);
  endtask

  // ---------------- directed + random sequence ----------------
  initial begin
    int c1, g, r;
    logic [7:0] ch;

    // reset, then power-on screen clear
    RST = 1'b1;
    repeat (3) @(negedge CLK);
    chk("rst_we", fb_we, 32'd0);
    chk("rst_addr", fb_addr, 32'd0);
    chk("rst_wdata", fb_wdata, 32'd0);
    chk("rst_col", cursor_col, 32'd0);
    chk("rst_row", cursor_row, 32'd0);
    chk("rst_ready", in_ready, 32'd0);
    RST = 1'b0;
    push_screen();
    drain("clr_scr");

    // 'A' at 0,0
    send(8'h41, 8'h1F);
    chk("a_addr", lat_addr, 32'd0);
    chk("a_data", lat_data, 32'h1F41);
    drain("a");
    chk("a_col", cursor_col, 32'd1);

    // back-to-back printable throughput
    send(8'h42, 8'h05);
    c1 = acc_cyc;
    send(8'h43, 8'h06);
    chk("tput", acc_cyc - c1, 32'd2);
    drain("bc");

    // bottom-right wrap
    send(8'h0D, 8'h00);
    drain("cr0");
    for (int i = 0; i < 29; i++) begin send(8'h0A, 8'h00); drain("lf_down"); end
    for (int i = 0; i < 79; i++) send(8'h61 + 8'(i % 26), 8'h17);
    drain("fill");
    chk("pre_z_col", cursor_col, 32'd79);
    chk("pre_z_row", cursor_row, 32'd29);
    send(8'h5A, 8'h2E);
    chk("z_addr", lat_addr, 32'd2399);
    drain("z");
    chk("z_col", cursor_col, 32'd0);
    chk("z_row", cursor_row, 32'd0);

    // CR then LF from 5,3
    for (int i = 0; i < 3; i++) send(8'h0A, 8'h00);
    for (int i = 0; i < 5; i++) send(8'h30 + 8'(i), 8'h70);
    drain("to53");
    send(8'h0D, 8'h00);
    drain("cr");
    chk("cr_col", cursor_col, 32'd0);
    send(8'h0A, 8'h00);
    drain("lf");
    chk("lf_row", cursor_row, 32'd4);

    // backspace at col 0, then at col 10 row 2
    send(8'h08, 8'h00);
    drain("bs0");
    send(8'h0C, 8'h00);
    drain("ff");
    send(8'h0A, 8'h00);
    send(8'h0A, 8'h00);
    for (int i = 0; i < 10; i++) send(8'h41 + 8'(i), 8'h0F);
    drain("to102");
    send(8'h08, 8'h00);
    chk("bs_addr", lat_addr, 32'd169);
    chk("bs_data", lat_data, 32'h0720);
    drain("bs");
    chk("bs_col", cursor_col, 32'd9);

    // random byte stream
    for (int i = 0; i < 250; i++) begin
      r = $urandom_range(0, 99);
      if (r < 70)      ch = 8'($urandom_range(8'h20, 8'h7E));
      else if (r < 78) ch = 8'h0D;
      else if (r < 84) ch = 8'h0A;
      else if (r < 92) ch = 8'h08;
      else if (r < 94) ch = 8'h09;
      else if (r < 99) ch = 8'($urandom_range(8'h7F, 8'hFF));
      else             ch = 8'h0C;
      send(ch, 8'($urandom_range(0, 255)));
      if (i % 8 == 7) drain("rnd");
    end
    drain("rnd_end");

    // reset in the middle of a screen clear
    send(8'h0C, 8'h00);
    g = 0;
    while (!(fb_we === 1'b1 && fb_addr === 12'd1000) && g < 6000) begin @(negedge CLK); g++; end
    chk("mid_reach", {31'd0, fb_we === 1'b1 && fb_addr === 12'd1000}, 32'd1);
    RST = 1'b1;
    @(negedge CLK);
    RST = 1'b0;
    chk("mid_we", fb_we, 32'd0);
    chk("mid_col", cursor_col, 32'd0);
    chk("mid_row", cursor_row, 32'd0);
    obs_q.delete();
    exp_q.delete();
    m_col = 0;
    m_row = 0;
    push_screen();
    drain("mid_clr");

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
